// File: rtl/rv_regfile_pkg.sv
// Shared types and constants for the RV32IM register file with scoreboard.
// Optional same-cycle write-through is enabled by defining REGFILE_SB_BYPASS_EN.
package rv_regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int AW_DEF = clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks destinations with a write in flight, flags WAW on issue.
// REGFILE_SB_BYPASS_EN lets a same-cycle writeback clear busy for readers and issue.
module regfile_scoreboard
    import rv_regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic              iss_ready,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_ok, iss_ok, iss_set, wr_clr;

    assign wr_ok  = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign iss_ok = !((ZERO_REG != 0) && (iss_addr == '0));

`ifdef REGFILE_SB_BYPASS_EN
    assign iss_ready = !busy_q[iss_addr] || (wr_ok && (wr_addr == iss_addr));
`else
    assign iss_ready = !busy_q[iss_addr];
`endif

    // Issue beats a same-cycle writeback to the same register: the new producer stays pending.
    assign iss_set = iss_en && iss_ready && iss_ok && !flush;
    assign wr_clr  = wr_ok && busy_q[wr_addr] && !(iss_set && (iss_addr == wr_addr));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_clr) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_set) begin
                busy_d[iss_addr] = 1'b1;
            end
            cnt_d = cnt_q + {{AW{1'b0}}, (iss_set && !busy_q[iss_addr])}
                          - {{AW{1'b0}}, wr_clr};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_SB_BYPASS_EN
            rd_busy[i] = busy_q[rd_addr[i*AW +: AW]]
                         && !(wr_clr && (wr_addr == rd_addr[i*AW +: AW]));
`else
            rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
`endif
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one writeback port and a scoreboard.
// Define REGFILE_SB_BYPASS_EN for same-cycle write-through to the read ports.
module regfile_sb
    import rv_regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_ready,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
                rd_data[i*XLEN +: XLEN] = '0;
`ifdef REGFILE_SB_BYPASS_EN
            end else if (wr_ok && (wr_addr == rd_addr[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = wr_data;
`endif
            end else begin
                rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .flush     (flush),
        .busy_cnt  (busy_cnt)
    );

endmodule
